serial_word_collector: RTL and testbench

- Downstream consumer of a 1-bit sum/carry stage: accepts that stage's serial sum bit and carry bit, LSB first.
- Assembles WIDTH sum bits into a parallel word with a valid/ready output handshake.
- Captures the carry of the final bit and flags words terminated early.
- Used as a formal/AIGER test vehicle; blocks X from upstream from reaching its outputs.

---
 rtl/serial_word_collector_pkg.sv | 20 ++
 rtl/serial_word_collector.sv | 138 +++++++++++++
 tb/tb_serial_word_collector.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_word_collector_pkg.sv
// serial_pkg: definitions shared by the serial word collector.
//   state_t     - collector FSM encoding (IDLE / SHIFT / HOLD)
//   cnt_width() - width of a counter able to hold 0..w
//   WIDTH_MIN / WIDTH_MAX - legal range of the word width parameter
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_word_collector.sv
// serial_word_collector: assembles LSB-first serial sum bits from a 1-bit
// sum/carry stage into a WIDTH-bit word with a valid/ready output handshake.
//
// Ports:
//   clk, rst_n            - rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   - serial bit handshake (in_ready = not holding)
//   sum_bit, carry_bit    - serial data, only sampled when a bit is accepted
//   in_last               - final bit of the word (qualified by in_valid)
//   out_valid / out_ready - assembled word handshake
//   out_word              - assembled word, bit 0 = first bit received
//   out_carry             - carry_bit captured with the final accepted bit
//   out_count             - number of bits received for the presented word
//   err_short             - word ended by in_last before WIDTH bits
//
// All data outputs are forced to 0 while out_valid is low.
//
// Build option: define SERIAL_COLLECTOR_FORMAL_EN to embed formal
// assertions/assumptions/covers; the default build contains none.
module serial_word_collector
    import serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sum_bit,
    input  logic             carry_bit,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic             out_carry,
    output logic [CNT_W-1:0] out_count,
    output logic             err_short
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_word_collector: WIDTH out of legal range");
    end

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic             carry_q, carry_n;
    logic             err_q, err_n;
    logic             accept;
    logic             final_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            cnt     <= cnt_n;
            carry_q <= carry_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        cnt_n     = cnt;
        carry_n   = carry_q;
        err_n     = err_q;
        cnt_inc   = cnt + CNT_W'(1);
        accept    = in_valid && (state != HOLD);
        final_bit = in_last || (cnt_inc == CNT_W'(WIDTH));

        case (state)
            // IDLE and SHIFT share one path: the counter is already 0 in
            // IDLE, so "write at position cnt" also places the first bit at 0.
            IDLE, SHIFT: begin
                if (accept) begin
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        if (cnt == CNT_W'(i)) begin
                            shreg_n[i] = sum_bit;
                        end
                    end
                    cnt_n = cnt_inc;
                    if (final_bit) begin
                        state_n = HOLD;
                        carry_n = carry_bit;
                        err_n   = (cnt_inc < CNT_W'(WIDTH));
                    end else begin
                        state_n = SHIFT;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    // Clear everything so the next word starts zero-filled.
                    state_n = IDLE;
                    shreg_n = '0;
                    cnt_n   = '0;
                    carry_n = 1'b0;
                    err_n   = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign out_word  = out_valid ? shreg   : '0;
    assign out_carry = out_valid ? carry_q : 1'b0;
    assign out_count = out_valid ? cnt     : '0;
    assign err_short = out_valid ? err_q   : 1'b0;

`ifdef SERIAL_COLLECTOR_FORMAL_EN
    a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
        !(out_valid && in_ready));
    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
        cnt <= CNT_W'(WIDTH));
    a_word_zero: assert property (@(posedge clk) disable iff (!rst_n)
        !out_valid |-> (out_word == '0));
    m_hold_valid: assume property (@(posedge clk) disable iff (!rst_n)
        (in_valid && !in_ready) |=> in_valid);
    m_out_ready: assume property (@(posedge clk) disable iff (!rst_n)
        s_eventually out_ready);
    a_word_done: assert property (@(posedge clk) disable iff (!rst_n)
        (in_valid && in_ready) |-> s_eventually out_valid);
    c_short: cover property (@(posedge clk) disable iff (!rst_n)
        err_short && out_valid);
`endif

endmodule

// File: tb/tb_serial_word_collector.sv
module tb_serial_word_collector;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, sum_bit, carry_bit, in_last;
    logic          out_valid, out_ready, out_carry, err_short;
    logic [W-1:0]  out_word;
    logic [CW-1:0] out_count;

    int n_cmp = 0;
    int n_bad = 0;

    serial_word_collector #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_bit   (sum_bit),
        .carry_bit (carry_bit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_carry (out_carry),
        .out_count (out_count),
        .err_short (err_short)
    );

    always #5 clk = ~clk;

    // Reference model: list of bits collected for the current word, and
    // whether a completed word is being presented.
    bit m_hold;
    bit m_bits[$];
    bit m_carry;
    bit m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_hold = 0; m_bits.delete(); m_carry = 0; m_err = 0;
            end else if (m_hold) begin
                if (out_ready === 1'b1) begin
                    m_hold = 0; m_bits.delete(); m_carry = 0; m_err = 0;
                end
            end else if (in_valid === 1'b1) begin
                m_bits.push_back(sum_bit);
                if (in_last === 1'b1 || m_bits.size() == W) begin
                    m_hold  = 1;
                    m_carry = carry_bit;
                    m_err   = (m_bits.size() < W);
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        logic [W-1:0] e_word;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                e_word = '0;
                if (m_hold)
                    foreach (m_bits[i]) e_word[i] = m_bits[i];
                chk("cyc in_ready",  in_ready,  !m_hold);
                chk("cyc out_valid", out_valid, m_hold);
                chk("cyc out_word",  out_word,  e_word);
                chk("cyc out_count", out_count, m_hold ? m_bits.size() : 0);
                chk("cyc out_carry", out_carry, m_hold ? m_carry : 1'b0);
                chk("cyc err_short", err_short, m_hold ? m_err : 1'b0);
            end
        end
    end

    task automatic idle_in();
        in_valid = 0; sum_bit = 1'bx; carry_bit = 1'bx; in_last = 1'bx;
    endtask

    task automatic put_bit(input logic s, input logic c, input logic l);
        @(negedge clk); #1;
        in_valid = 1; sum_bit = s; carry_bit = c; in_last = l;
    endtask

    task automatic gap();
        @(negedge clk); #1;
        idle_in();
    endtask

    // Sends n bits of w LSB first; the last one carries last_c and, if
    // use_last, in_last. Returns at the negedge after the final bit's edge.
    task automatic send_word(input logic [W-1:0] w, input int n, input logic last_c,
                             input bit use_last, input bit gaps);
        for (int i = 0; i < n; i++) begin
            put_bit(w[i], (i == n - 1) ? last_c : logic'($urandom_range(1)),
                    (use_last && i == n - 1) ? 1'b1 : 1'b0);
            if (gaps && i != n - 1) gap();
        end
        @(negedge clk);
    endtask

    task automatic handshake();
        #1; idle_in(); out_ready = 1;
        @(negedge clk);
        chk("hs out_valid", out_valid, 1'b0);
        chk("hs out_word",  out_word,  '0);
        chk("hs out_count", out_count, '0);
        chk("hs in_ready",  in_ready,  1'b1);
        #1; out_ready = 0;
    endtask

    initial begin
        rst_n = 0; out_ready = 0; idle_in();
        #1;
        chk("rst in_ready",  in_ready,  1'b1);
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst out_word",  out_word,  '0);
        repeat (2) @(negedge clk);
        #1; rst_n = 1;

        // Full word 1,0,1,1,0,0,1,0 with final carry 1.
        send_word(8'h4D, 8, 1'b1, 0, 0);
        chk("w1 out_valid", out_valid, 1'b1);
        chk("w1 out_word",  out_word,  8'h4D);
        chk("w1 out_carry", out_carry, 1'b1);
        chk("w1 out_count", out_count, 4'd8);
        chk("w1 err_short", err_short, 1'b0);
        // Held with out_ready low while upstream keeps offering ones.
        for (int i = 0; i < 5; i++) begin
            #1; in_valid = 1; sum_bit = 1; carry_bit = 0; in_last = 0;
            @(negedge clk);
        end
        chk("hold out_word",  out_word,  8'h4D);
        chk("hold in_ready",  in_ready,  1'b0);
        chk("hold out_count", out_count, 4'd8);
        handshake();

        // Short word 1,1,1 ended by in_last.
        send_word(8'h07, 3, 1'b0, 1, 0);
        chk("short out_word",  out_word,  8'h07);
        chk("short out_count", out_count, 4'd3);
        chk("short err_short", err_short, 1'b1);
        chk("short in_ready",  in_ready,  1'b0);
        handshake();

        // Reset in the middle of a word.
        send_word(8'h0B, 4, 1'b0, 0, 0);
        #1; idle_in(); rst_n = 0;
        #1;
        chk("mid rst out_valid", out_valid, 1'b0);
        chk("mid rst in_ready",  in_ready,  1'b1);
        chk("mid rst out_count", out_count, '0);
        #1; rst_n = 1;
        send_word(8'hA5, 8, 1'b1, 0, 0);
        chk("post rst out_word",  out_word,  8'hA5);
        chk("post rst out_count", out_count, 4'd8);
        chk("post rst out_carry", out_carry, 1'b1);
        handshake();

        // X on the data lines between valid bits.
        send_word(8'h3C, 8, 1'b0, 0, 1);
        chk("xgap out_word",  out_word,  8'h3C);
        chk("xgap out_carry", out_carry, 1'b0);
        handshake();

        // in_last coinciding with the 8th bit.
        send_word(8'h81, 8, 1'b0, 1, 0);
        chk("last8 out_word",  out_word,  8'h81);
        chk("last8 out_count", out_count, 4'd8);
        chk("last8 err_short", err_short, 1'b0);
        handshake();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk); #1;
            in_valid = ($urandom_range(99) < 70);
            if (in_valid) begin
                sum_bit   = logic'($urandom_range(1));
                carry_bit = logic'($urandom_range(1));
                in_last   = ($urandom_range(99) < 12);
            end else begin
                sum_bit = 1'bx; carry_bit = 1'bx; in_last = 1'bx;
            end
            out_ready = ($urandom_range(99) < 40);
            if ($urandom_range(199) == 0) begin
                rst_n = 0;
                #1;
                chk("rnd rst out_valid", out_valid, 1'b0);
                #1; rst_n = 1;
            end
        end
        @(negedge clk); #1; idle_in(); out_ready = 0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
